// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory load/store stage with lane alignment, extension and timeout
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              store_q, store_d;
  logic              unsigned_q, unsigned_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              misaligned;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       rd_shift;
  logic [15:0]       rd_half;
  logic [31:0]       ld_data;

  always_comb begin
    misaligned = (req_size == 2'b11) ||
                 (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    case (req_size)
      2'b00:   begin st_be = 4'b0001 << req_addr[1:0]; st_wdata = {4{req_wdata[7:0]}};  end
      2'b01:   begin st_be = 4'b0011 << req_addr[1:0]; st_wdata = {2{req_wdata[15:0]}}; end
      default: begin st_be = 4'b1111;                  st_wdata = req_wdata;            end
    endcase
  end

  // Load extraction works on the latched lane/size against the word returned with the ack.
  always_comb begin
    rd_shift = mem_rdata >> {lane_q, 3'b000};
    rd_half  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_data = {(unsigned_q ? 24'h0 : {24{rd_shift[7]}}), rd_shift[7:0]};
      2'b01:   ld_data = {(unsigned_q ? 16'h0 : {16{rd_half[15]}}), rd_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    store_d      = store_q;
    unsigned_d   = unsigned_q;
    size_d       = size_q;
    lane_d       = lane_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d      = req_store;
          unsigned_d   = req_unsigned;
          size_d       = req_size;
          lane_d       = req_addr[1:0];
          resp_rdata_d = 32'h0;
          if (misaligned) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = S_WAIT;
            cnt_d       = '0;
            resp_err_d  = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_store;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = req_store ? st_be : 4'b0000;
            mem_wdata_d = req_store ? st_wdata : 32'h0;
          end
        end
      end
      S_WAIT: begin
        if (mem_ack || (cnt_q + CNT_W'(1)) == TIMEOUT_C) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = !mem_ack;
          resp_rdata_d = (mem_ack && !store_q) ? ld_data : 32'h0;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = 32'h0;
          mem_be_d     = 4'b0000;
          mem_wdata_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d      = S_IDLE;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
      end
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      store_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      store_q      <= store_d;
      unsigned_q   <= unsigned_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
